ex_wbck_arb: RTL

- Write-back side of the integer register file: the block that drives wbck_dest_wen / wbck_dest_idx / wbck_dest_dat.
- Merges two result sources onto the single regfile write port:
  - the single-cycle ALU path;
  - the long-pipe path (LSU loads, mul/div), buffered in a small FIFO.
- Fixed priority with an anti-starvation counter. One regfile write per cycle.

---
 rtl/ex_wbck_arb_if.sv | 58 +++++
 rtl/ex_wbck_arb.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ex_wbck_arb_if.sv
// Write-back arbiter bundle: ALU and long-pipe results in,
// regfile write port and buffer status out.
`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

interface ex_wbck_arb_if;
  logic                         alu_wbck_i_valid;
  logic                         alu_wbck_i_ready;
  logic [`E203_XLEN-1:0]        alu_wbck_i_dat;
  logic [`E203_RFIDX_WIDTH-1:0] alu_wbck_i_rdidx;

  logic                         longp_wbck_i_valid;
  logic                         longp_wbck_i_ready;
  logic [`E203_XLEN-1:0]        longp_wbck_i_dat;
  logic [`E203_RFIDX_WIDTH-1:0] longp_wbck_i_rdidx;
  logic                         longp_wbck_i_rdwen;

  logic                         wbck_dest_wen;
  logic [`E203_RFIDX_WIDTH-1:0] wbck_dest_idx;
  logic [`E203_XLEN-1:0]        wbck_dest_dat;
  logic                         lbuf_empty;

  modport master (
    output alu_wbck_i_valid,
    output alu_wbck_i_dat,
    output alu_wbck_i_rdidx,
    output longp_wbck_i_valid,
    output longp_wbck_i_dat,
    output longp_wbck_i_rdidx,
    output longp_wbck_i_rdwen,
    input  alu_wbck_i_ready,
    input  longp_wbck_i_ready,
    input  wbck_dest_wen,
    input  wbck_dest_idx,
    input  wbck_dest_dat,
    input  lbuf_empty
  );

  modport slave (
    input  alu_wbck_i_valid,
    input  alu_wbck_i_dat,
    input  alu_wbck_i_rdidx,
    input  longp_wbck_i_valid,
    input  longp_wbck_i_dat,
    input  longp_wbck_i_rdidx,
    input  longp_wbck_i_rdwen,
    output alu_wbck_i_ready,
    output longp_wbck_i_ready,
    output wbck_dest_wen,
    output wbck_dest_idx,
    output wbck_dest_dat,
    output lbuf_empty
  );
endinterface

// File: rtl/ex_wbck_arb.sv
// Regfile write-back arbiter: ALU vs buffered long-pipe results,
// fixed priority to the long pipe with an ALU anti-starvation counter.
`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

module ex_wbck_arb #(
  parameter int LBUF_DEPTH = 2,
  parameter int LBUF_PTR_W = 1,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input logic          clk,
  input logic          rst_n,
  ex_wbck_arb_if.slave bus
);

  localparam int XW = `E203_XLEN;
  localparam int IW = `E203_RFIDX_WIDTH;
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(STARVE_MAX);

  typedef logic [LBUF_PTR_W:0]   ptr_t;
  typedef logic [LBUF_PTR_W-1:0] addr_t;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XW-1:0] buf_dat_q [LBUF_DEPTH];
  logic [IW-1:0] buf_idx_q [LBUF_DEPTH];
  logic          buf_wen_q [LBUF_DEPTH];

  addr_t wr_addr;
  addr_t rd_addr;
  logic  empty;
  logic  full;
  logic  push;
  logic  pop;
  logic  head_w;
  logic  force_alu;
  logic  head_win;
  logic  alu_hsk;

  assign wr_addr = wr_ptr_q[LBUF_PTR_W-1:0];
  assign rd_addr = rd_ptr_q[LBUF_PTR_W-1:0];

  // Occupancy from pointer compare; wrap bit splits full/empty
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[LBUF_PTR_W] != rd_ptr_q[LBUF_PTR_W])
         && (wr_addr == rd_addr);
  end

  // Per-cycle arbitration of the single regfile write port
  always_comb begin
    head_w    = !empty && buf_wen_q[rd_addr];
    force_alu = (cnt_q == CMAX);
    head_win  = head_w && !force_alu;

    // rdwen=0 heads drain for free; writing heads drain when they win
    pop  = !empty && (!buf_wen_q[rd_addr] || head_win);
    push = bus.longp_wbck_i_valid && !full;

    bus.longp_wbck_i_ready = !full;
    bus.alu_wbck_i_ready   = !head_win;
    bus.lbuf_empty         = empty;

    bus.wbck_dest_wen = bus.alu_wbck_i_valid;
    bus.wbck_dest_idx = bus.alu_wbck_i_rdidx;
    bus.wbck_dest_dat = bus.alu_wbck_i_dat;
    if (head_win) begin
      bus.wbck_dest_wen = 1'b1;
      bus.wbck_dest_idx = buf_idx_q[rd_addr];
      bus.wbck_dest_dat = buf_dat_q[rd_addr];
    end

    alu_hsk = bus.alu_wbck_i_valid && !head_win;
  end

  // Next pointers and starvation count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);

    if (!bus.alu_wbck_i_valid || alu_hsk) begin
      cnt_d = '0;
    end else if (cnt_q != CMAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Control state; reset empties the buffer immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care while not in use
  always_ff @(posedge clk) begin
    if (push) begin
      buf_dat_q[wr_addr] <= bus.longp_wbck_i_dat;
      buf_idx_q[wr_addr] <= bus.longp_wbck_i_rdidx;
      buf_wen_q[wr_addr] <= bus.longp_wbck_i_rdwen;
    end
  end

endmodule
